// File: rtl/shift_sub_divider_if.sv
// Operand/result bundle for the shift-subtract divider.
// The master drives the request; the slave returns registered results.
interface shift_sub_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op_signed, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, op_signed, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/shift_sub_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Optional two's-complement mode is enabled by defining SIGNED_DIV_EN.
module shift_sub_divider #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    shift_sub_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    always_comb begin
        t = {r, q[WIDTH-1]} - {1'b0, dvs};
        if (!t[WIDTH]) begin
            r_nx = t[WIDTH-1:0];
            q_nx = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_nx = {r[WIDTH-2:0], q[WIDTH-1]};
            q_nx = {q[WIDTH-2:0], 1'b0};
        end
    end

`ifdef SIGNED_DIV_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;
    logic neg_r;

    assign a_neg = bus.op_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.op_signed & bus.divisor[WIDTH-1];
    assign a_in  = a_neg ? -bus.dividend : bus.dividend;
    assign b_in  = b_neg ? -bus.divisor : bus.divisor;
    // Remainder follows the dividend sign (truncating division).
    assign res_q = neg_q ? -q_nx : q_nx;
    assign res_r = neg_r ? -r_nx : r_nx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end
    end
`else
    logic unused_op_signed;

    assign unused_op_signed = bus.op_signed;
    assign a_in  = bus.dividend;
    assign b_in  = bus.divisor;
    assign res_q = q_nx;
    assign res_r = r_nx;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            r      <= '0;
            q      <= '0;
            dvs    <= '0;
            cnt    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        r   <= '0;
                        q   <= a_in;
                        dvs <= b_in;
                        cnt <= '0;
                        if (bus.divisor == '0) begin
                            quo_q  <= '1;
                            rem_q  <= bus.dividend;
                            dbz_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    r   <= r_nx;
                    q   <= q_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        quo_q  <= res_q;
                        rem_q  <= res_r;
                        dbz_q  <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/shift_sub_divider.md
Name: shift_sub_divider

Overview:
- Sequential restoring (shift-subtract) unsigned divider; the inverse companion of the team's shift-add multiplier datapath.
- Resolves one quotient bit per clock.
- Sits beside the MAC multiplier under a shared operand/controller front end.
- Start/busy/done handshake; registered results held until the next accepted start.

Parameters:
- WIDTH, 8, operand width in bits (dividend, divisor, quotient, remainder); legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op_signed  input  1  signed-operation select; used only when SIGNED_DIV_EN is defined, else ignored
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- quotient  output  WIDTH  registered result quotient
- remainder  output  WIDTH  registered result remainder
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  registered flag for the last result

Behaviour:
- Reset:
  - Clock: clk. Reset: reset, synchronous, active-low.
  - While reset is low, every output and internal register clears (quotient=0, remainder=0, busy=0, done=0, div_by_zero=0) and the state goes to IDLE.
  - Reset mid-operation aborts the division. No done is produced and the prior result is lost.
- States:
  - IDLE: start=1 latches the operands and clears the iteration counter. R (WIDTH bits) is set to 0 and Q is set to dividend.
    - If divisor!=0, go to RUN.
    - If divisor==0, go to DONE.
  - RUN: busy=1. Each cycle:
    - Form T = {R, Q[WIDTH-1]} - {0, divisor}, a (WIDTH+1)-bit subtract.
    - If T is non-negative: R <= T[WIDTH-1:0] and Q <= {Q[WIDTH-2:0], 1}.
    - Otherwise: R <= {R[WIDTH-2:0], Q[WIDTH-1]} and Q <= {Q[WIDTH-2:0], 0}.
    - The counter increments. After the WIDTH-th iteration, quotient<=Q, remainder<=R, div_by_zero<=0, and the state goes to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then the state returns to IDLE unconditionally.
- Divide by zero:
  - In the IDLE->DONE transition, quotient<=all ones, remainder<=dividend, div_by_zero<=1.
- Latency:
  - With start high in cycle 0 (sampled at the end of cycle 0), a nonzero divisor gives done high in cycle WIDTH+1.
  - A zero divisor gives done high in cycle 1.
- Throughput:
  - A new start is accepted in the cycle after done (IDLE).
  - Back-to-back operation is one division every WIDTH+2 cycles.
- start while in RUN or DONE is ignored: no queuing, no effect on the in-flight operation.
- Operands are captured only at acceptance. Changes to dividend/divisor afterwards have no effect.
- quotient, remainder and div_by_zero hold their previous values throughout RUN. They update only on the transition into DONE.
- Arithmetic invariant (unsigned, divisor!=0): dividend = quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro SIGNED_DIV_EN.
- Defined: op_signed=1 selects two's-complement division.
  - At acceptance, operands are converted to magnitudes and the sign bits are stored.
  - The unsigned core runs unchanged, with identical latency.
  - At DONE, quotient is negated if the operand signs differ. Remainder takes the sign of the dividend (truncating division).
  - Most-negative / -1 (WIDTH=8: 0x80/0xFF) yields quotient=0x80, remainder=0, div_by_zero=0.
  - Signed divide-by-zero follows the unsigned rule: quotient all ones, remainder=dividend.
  - op_signed=0 behaves exactly as the undefined build.
- Undefined: op_signed is ignored; all operations are unsigned; no sign logic is synthesized.

Test Plan:
- WIDTH=8, start in cycle 0 with 200/7 -> busy in cycles 1-8; done only in cycle 9; quotient=28 (0x1C), remainder=4, div_by_zero=0.
- 5/0 -> done in cycle 1; quotient=0xFF, remainder=5, div_by_zero=1; busy never asserts. A following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Boundaries: 255/1 -> 255 r 0; 3/200 -> 0 r 3; 255/255 -> 1 r 0; 0/9 -> 0 r 0. Each gives done exactly once.
- Start 100/9, then pulse start with 50/5 in cycle 4 -> second request ignored; result 11 r 1 in cycle 9. Immediate restart in cycle 10 is accepted.
- Start 200/7, drive reset low in cycle 5 for one cycle -> all outputs 0; no done. Next start of 10/3 gives 3 r 1.
- SIGNED_DIV_EN, op_signed=1: -7/2 -> quotient 0xFD (-3), remainder 0xFF (-1); 7/-2 -> 0xFD, r 1; 0x80/0xFF -> 0x80, r 0.
